// File: rtl/wb_stage_buf_pkg.sv
// Shared write-back types and constants for the MEM->WB stage buffer.
// The entry width is derived from the data/address widths so the storage scales with the core.
package wb_stage_buf_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int DATA_W_DEF     = 32;

    typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_bus_t;
    typedef logic [DATA_W_DEF-1:0]     reg_bus_t;

    localparam reg_bus_t      ZERO_WORD     = '0;
    localparam reg_addr_bus_t NOP_REG_ADDR  = '0;
    localparam logic          WRITE_ENABLE  = 1'b1;
    localparam logic          WRITE_DISABLE = 1'b0;

    typedef struct packed {
        reg_addr_bus_t wd;
        logic          wreg;
        reg_bus_t      wdata;
        logic          whilo;
        reg_bus_t      hi;
        reg_bus_t      lo;
    } wb_entry_t;

    // Without HI/LO the stored entry shrinks to just the register-file write.
    function automatic int entry_width(input int data_w, input int addr_w, input bit hilo_en);
        return addr_w + 1 + data_w + (hilo_en ? (1 + 2 * data_w) : 0);
    endfunction

endpackage

// File: rtl/wb_stage_buf_fifo.sv
// sync_fifo_core: DEPTH-entry in-order storage with valid/ready on both sides and a
// synchronous flush. Pointers wrap by explicit compare so any DEPTH >= 1 works.
module sync_fifo_core #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Readiness comes from the registered count only, so a full buffer never
    // accepts in the same cycle it pops.
    assign push_ready = (count < CNT_W'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push       = push_valid & push_ready & ~flush;
    assign pop        = pop_valid & pop_ready & ~flush;
    assign pop_data   = mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/wb_stage_buf.sv
// MEM->WB stage buffer: carries register-file and HI/LO writes through an in-order
// buffer; an empty buffer presents a NOP write so write-back never sees stale data.
module wb_stage_buf
    import wb_stage_buf_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int REG_ADDR_W = 5,
    parameter  int DEPTH      = 2,
    parameter  int HILO_EN    = 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_wd,
    input  logic                  in_wreg,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic                  in_whilo,
    input  logic [DATA_W-1:0]     in_hi,
    input  logic [DATA_W-1:0]     in_lo,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_wd,
    output logic                  out_wreg,
    output logic [DATA_W-1:0]     out_wdata,
    output logic                  out_whilo,
    output logic [DATA_W-1:0]     out_hi,
    output logic [DATA_W-1:0]     out_lo,
    output logic [CNT_W-1:0]      count
);

    localparam int BASE_W = REG_ADDR_W + 1 + DATA_W;
    localparam int ENT_W  = entry_width(DATA_W, REG_ADDR_W, HILO_EN != 0);

    logic [ENT_W-1:0]      in_entry;
    logic [ENT_W-1:0]      head_entry;
    logic [REG_ADDR_W-1:0] head_wd;
    logic                  head_wreg;
    logic [DATA_W-1:0]     head_wdata;

    assign in_entry[BASE_W-1:0]            = {in_wd, in_wreg, in_wdata};
    assign {head_wd, head_wreg, head_wdata} = head_entry[BASE_W-1:0];

    sync_fifo_core #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (in_entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_entry),
        .count      (count)
    );

    // Storage is not reset, so every field is masked while the buffer is empty.
    assign out_wd    = out_valid ? head_wd    : '0;
    assign out_wreg  = out_valid ? head_wreg  : WRITE_DISABLE;
    assign out_wdata = out_valid ? head_wdata : '0;

    if (HILO_EN != 0) begin : g_hilo
        logic              head_whilo;
        logic [DATA_W-1:0] head_hi;
        logic [DATA_W-1:0] head_lo;

        assign in_entry[ENT_W-1:BASE_W]        = {in_whilo, in_hi, in_lo};
        assign {head_whilo, head_hi, head_lo}  = head_entry[ENT_W-1:BASE_W];
        assign out_whilo = out_valid ? head_whilo : WRITE_DISABLE;
        assign out_hi    = out_valid ? head_hi    : '0;
        assign out_lo    = out_valid ? head_lo    : '0;
    end else begin : g_no_hilo
        logic unused_hilo;

        assign unused_hilo = ^{in_whilo, in_hi, in_lo};
        assign out_whilo   = WRITE_DISABLE;
        assign out_hi      = '0;
        assign out_lo      = '0;
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: a DEPTH=2 instance with HI/LO and a DEPTH=3 instance without,
// both driven by the same stimulus and checked against queue models.
module tb_wb_stage_buf;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_wd = '0;
    logic        in_wreg = 1'b0;
    logic [31:0] in_wdata = '0;
    logic        in_whilo = 1'b0;
    logic [31:0] in_hi = '0;
    logic [31:0] in_lo = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_wreg, a_out_whilo;
    logic [4:0]  a_out_wd;
    logic [31:0] a_out_wdata, a_out_hi, a_out_lo;
    logic [1:0]  a_count;
    logic        b_in_ready, b_out_valid, b_out_wreg, b_out_whilo;
    logic [4:0]  b_out_wd;
    logic [31:0] b_out_wdata, b_out_hi, b_out_lo;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    wb_stage_buf #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(2), .HILO_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_whilo(in_whilo),
        .in_hi(in_hi), .in_lo(in_lo), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_wd(a_out_wd), .out_wreg(a_out_wreg),
        .out_wdata(a_out_wdata), .out_whilo(a_out_whilo), .out_hi(a_out_hi),
        .out_lo(a_out_lo), .count(a_count)
    );

    wb_stage_buf #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(3), .HILO_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_whilo(in_whilo),
        .in_hi(in_hi), .in_lo(in_lo), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_wd(b_out_wd), .out_wreg(b_out_wreg),
        .out_wdata(b_out_wdata), .out_whilo(b_out_whilo), .out_hi(b_out_hi),
        .out_lo(b_out_lo), .count(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t ea, eb;
        ea = (qa.size() > 0) ? qa[0] : '0;
        eb = (qb.size() > 0) ? qb[0] : '0;
        eb.whilo = 1'b0;
        eb.hi    = '0;
        eb.lo    = '0;
        chk("a_valid", 64'(a_out_valid), 64'(qa.size() != 0));
        chk("a_count", 64'(a_count), 64'(qa.size()));
        chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
        chk("a_entry", 64'({a_out_wd, a_out_wreg, a_out_wdata}), 64'({ea.wd, ea.wreg, ea.wdata}));
        chk("a_hilo", 64'({a_out_whilo, a_out_hi}), 64'({ea.whilo, ea.hi}));
        chk("a_lo", 64'(a_out_lo), 64'(ea.lo));
        chk("b_valid", 64'(b_out_valid), 64'(qb.size() != 0));
        chk("b_count", 64'(b_count), 64'(qb.size()));
        chk("b_in_ready", 64'(b_in_ready), 64'(qb.size() < 3));
        chk("b_entry", 64'({b_out_wd, b_out_wreg, b_out_wdata}), 64'({eb.wd, eb.wreg, eb.wdata}));
        chk("b_hilo", 64'({b_out_whilo, b_out_hi}), 64'({eb.whilo, eb.hi}));
        chk("b_lo", 64'(b_out_lo), 64'(eb.lo));
    endtask

    // One clock: decide transfers from pre-edge occupancy, advance the models, then compare.
    task automatic step();
        ent_t e;
        bit push_a, pop_a, push_b, pop_b;
        e      = '{in_wd, in_wreg, in_wdata, in_whilo, in_hi, in_lo};
        push_a = in_valid && (qa.size() < 2) && !flush;
        pop_a  = (qa.size() > 0) && out_ready && !flush;
        push_b = in_valid && (qb.size() < 3) && !flush;
        pop_b  = (qb.size() > 0) && out_ready && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pop_a)  void'(qa.pop_front());
            if (push_a) qa.push_back(e);
            if (pop_b)  void'(qb.pop_front());
            if (push_b) qb.push_back(e);
        end
        check_all();
    endtask

    task automatic drive(input bit v, input logic [4:0] wd, input logic [31:0] wdata,
                         input bit whilo, input logic [31:0] hi, input bit rdy);
        in_valid  = v;
        in_wd     = wd;
        in_wreg   = 1'b1;
        in_wdata  = wdata;
        in_whilo  = whilo;
        in_hi     = hi;
        in_lo     = ~wdata;
        out_ready = rdy;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();

        // Async reset in the middle of a cycle with data held.
        drive(1, 5'd3, 32'h1234_5678, 1, 32'hAAAA_5555, 0);
        step();
        step();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check_all();
        @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;

        // Single push, hold under backpressure, then pop.
        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 32'h0, 0);
        step();
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        step();

        // Fill with backpressure; third push is refused by the DEPTH=2 instance.
        drive(1, 5'd1, 32'h11, 0, 32'h0, 0);
        step();
        drive(1, 5'd2, 32'h22, 0, 32'h0, 0);
        step();
        drive(1, 5'd3, 32'h33, 0, 32'h0, 0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        step();

        // Push and pop together at count=1, then an 8-entry stream.
        drive(1, 5'd7, 32'h70, 0, 32'h0, 0);
        step();
        drive(1, 5'd8, 32'h80, 0, 32'h0, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'(i + 9), 32'h100 + 32'(i), 0, 32'h0, 1);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Flush with both buffers holding two entries and a concurrent push/pop.
        drive(1, 5'd4, 32'hA1, 0, 32'h0, 0);
        step();
        drive(1, 5'd6, 32'hA2, 0, 32'h0, 0);
        step();
        drive(1, 5'd9, 32'hA3, 0, 32'h0, 1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        // HI/LO entry: tied off in the instance built without HI/LO.
        drive(1, 5'd10, 32'hCAFE_F00D, 1, 32'hFFFF_0000, 0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Random traffic including bubbles and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_wd     = 5'($urandom);
            in_wreg   = 1'($urandom);
            in_wdata  = $urandom;
            in_whilo  = 1'($urandom);
            in_hi     = $urandom;
            in_lo     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            step();
        end
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
